// File: rtl/genius_round_engine_if.sv
// Purpose: player-side bundle of the Genius round engine (controls in, LEDs/score/flags out).
// Latency: pure wiring, no storage.
// Backpressure: none; buttons are levels and outputs are continuously valid.
// Ports: start, player_input, speed_fast, difficulty, game_mode (front-end -> engine);
//        leds, game_active, score, round_len, victory, defeat (engine -> display drivers).
interface genius_round_engine_if #(
    parameter int N_COLORS = 4
);
    logic                start;
    logic [N_COLORS-1:0] player_input;
    logic                speed_fast;
    logic [1:0]          difficulty;
    logic                game_mode;
    logic [N_COLORS-1:0] leds;
    logic                game_active;
    logic [7:0]          score;
    logic [7:0]          round_len;
    logic                victory;
    logic                defeat;

    // Front-end / display side drives the controls and watches the results.
    modport master (
        output start, player_input, speed_fast, difficulty, game_mode,
        input  leds, game_active, score, round_len, victory, defeat
    );

    // Engine side.
    modport slave (
        input  start, player_input, speed_fast, difficulty, game_mode,
        output leds, game_active, score, round_len, victory, defeat
    );
endinterface

// File: rtl/genius_round_engine.sv
// Purpose: Genius/Simon core: grows an LFSR colour sequence each round, shows it, checks presses.
// Latency: start at cycle t -> EXTEND at t+1 -> first LED at t+2; verdict one cycle after a press.
// Backpressure: none; start only honoured in IDLE/WIN/LOSE, button edges only honoured in WAIT_INPUT.
// Ports: clk, rst_n (async active-low); io = genius_round_engine_if.slave (controls in, leds/score/flags out).
module genius_round_engine #(
    parameter int          N_COLORS       = 4,
    parameter int          MAX_LEN        = 32,
    parameter int          SHOW_SLOW      = 400,
    parameter int          SHOW_FAST      = 100,
    parameter int          GAP_CYCLES     = 50,
    parameter int          TIMEOUT_CYCLES = 2000,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input logic                   clk,
    input logic                   rst_n,
    genius_round_engine_if.slave  io
);
    localparam int CW   = (N_COLORS > 1) ? $clog2(N_COLORS) : 1;
    localparam int IW   = $clog2(MAX_LEN);
    localparam int TA   = (SHOW_SLOW > SHOW_FAST) ? SHOW_SLOW : SHOW_FAST;
    localparam int TB   = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
    localparam int TMAX = (TA > TB) ? TA : TB;
    localparam int TW   = $clog2(TMAX + 1);

    // One shared timer serves show, gap and input timeout; compare against last-count values.
    localparam logic [TW-1:0] SLOW_LAST = TW'(SHOW_SLOW - 1);
    localparam logic [TW-1:0] FAST_LAST = TW'(SHOW_FAST - 1);
    localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    MAX_LEN8  = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE, S_EXTEND, S_SHOW_ON, S_SHOW_OFF, S_WAIT_INPUT, S_ROUND_OK, S_WIN, S_LOSE
    } state_t;

    state_t          state, state_nxt;
    logic [15:0]     lfsr;
    logic [CW-1:0]   seq [MAX_LEN];
    logic [7:0]      round_len;
    logic [7:0]      idx;
    logic [7:0]      score;
    logic [7:0]      target;
    logic            mode_rev;
    logic [TW-1:0]   timer;
    logic [TW-1:0]   show_last;
    logic            prev_zero;

    logic [CW-1:0]       cur_color;
    logic [N_COLORS-1:0] cur_onehot;
    logic                press;
    logic                press_ok;
    logic                last_elem;
    logic                show_done;
    logic                gap_done;
    logic                timed_out;
    logic [7:0]          idx_plus;
    logic [7:0]          diff_len;

    always_comb begin
        cur_color             = seq[idx[IW-1:0]];
        cur_onehot            = '0;
        cur_onehot[cur_color] = 1'b1;
        // Edge from an all-released cycle; multi-bit presses fall through to press_ok=0.
        press     = prev_zero && (io.player_input != '0);
        press_ok  = (io.player_input == cur_onehot);
        last_elem = mode_rev ? (idx == 8'd0) : (idx == round_len - 8'd1);
        show_done = (timer == show_last);
        gap_done  = (timer == GAP_LAST);
        timed_out = (timer == TO_LAST);
        idx_plus  = idx + 8'd1;
        diff_len  = {3'b000, io.difficulty, 3'b000} + 8'd8;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_WIN, S_LOSE: if (io.start) state_nxt = S_EXTEND;
            S_EXTEND:              state_nxt = S_SHOW_ON;
            S_SHOW_ON:             if (show_done) state_nxt = S_SHOW_OFF;
            S_SHOW_OFF: begin
                if (gap_done) state_nxt = (idx_plus == round_len) ? S_WAIT_INPUT : S_SHOW_ON;
            end
            S_WAIT_INPUT: begin
                if (press) begin
                    if (!press_ok)     state_nxt = S_LOSE;
                    else if (last_elem) state_nxt = S_ROUND_OK;
                end else if (timed_out) begin
                    state_nxt = S_LOSE;
                end
            end
            S_ROUND_OK:            state_nxt = (round_len == target) ? S_WIN : S_EXTEND;
            default:               state_nxt = S_IDLE;
        endcase
    end

    // Sequence RAM carries no reset: round_len restarts at 0, so stale entries are never read.
    always_ff @(posedge clk) begin
        if (state == S_EXTEND) seq[round_len[IW-1:0]] <= lfsr[CW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr      <= LFSR_SEED;
            round_len <= '0;
            idx       <= '0;
            score     <= '0;
            target    <= 8'd8;
            mode_rev  <= 1'b0;
            timer     <= '0;
            show_last <= SLOW_LAST;
            prev_zero <= 1'b0;
        end else begin
            lfsr      <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            prev_zero <= (io.player_input == '0);
            case (state)
                S_IDLE, S_WIN, S_LOSE: begin
                    if (io.start) begin
                        target    <= (diff_len > MAX_LEN8) ? MAX_LEN8 : diff_len;
                        mode_rev  <= io.game_mode;
                        score     <= '0;
                        round_len <= '0;
                    end
                end
                S_EXTEND: begin
                    round_len <= round_len + 8'd1;
                    idx       <= '0;
                    timer     <= '0;
                    show_last <= io.speed_fast ? FAST_LAST : SLOW_LAST;
                end
                S_SHOW_ON: begin
                    timer <= show_done ? '0 : timer + 1'b1;
                end
                S_SHOW_OFF: begin
                    if (gap_done) begin
                        timer <= '0;
                        if (idx_plus == round_len) begin
                            idx <= mode_rev ? round_len - 8'd1 : 8'd0;
                        end else begin
                            idx       <= idx_plus;
                            show_last <= io.speed_fast ? FAST_LAST : SLOW_LAST;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_WAIT_INPUT: begin
                    if (press) begin
                        timer <= '0;
                        if (press_ok && !last_elem) idx <= mode_rev ? idx - 8'd1 : idx_plus;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_ROUND_OK: begin
                    if (score != 8'hFF) score <= score + 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign io.leds        = (state == S_SHOW_ON) ? cur_onehot : '0;
    assign io.game_active = !(state == S_IDLE || state == S_WIN || state == S_LOSE);
    assign io.score       = score;
    assign io.round_len   = round_len;
    assign io.victory     = (state == S_WIN);
    assign io.defeat      = (state == S_LOSE);
endmodule

// File: tb/tb_genius_round_engine.sv
// Purpose: self-checking bench for genius_round_engine (4-colour and 8-colour instances).
// Latency: expectations are cycle-exact against the start -> EXTEND -> SHOW_ON timeline.
// Backpressure: n/a; the bench plays the player role through the interface.
module tb_genius_round_engine;
    localparam int T_SLOW = 4;
    localparam int T_FAST = 2;
    localparam int T_GAP  = 2;
    localparam int T_TO   = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] pi;
    logic       speed;
    logic [1:0] diff;
    logic       mode;
    logic       sel;

    always #5 clk = ~clk;

    genius_round_engine_if #(.N_COLORS(4)) a_if();
    genius_round_engine_if #(.N_COLORS(8)) b_if();

    assign a_if.start        = start & ~sel;
    assign a_if.player_input = pi[3:0];
    assign a_if.speed_fast   = speed;
    assign a_if.difficulty   = diff;
    assign a_if.game_mode    = mode;
    assign b_if.start        = start & sel;
    assign b_if.player_input = pi;
    assign b_if.speed_fast   = speed;
    assign b_if.difficulty   = diff;
    assign b_if.game_mode    = mode;

    genius_round_engine #(
        .N_COLORS(4), .MAX_LEN(32), .SHOW_SLOW(T_SLOW), .SHOW_FAST(T_FAST),
        .GAP_CYCLES(T_GAP), .TIMEOUT_CYCLES(T_TO), .LFSR_SEED(16'hACE1)
    ) dut_a (.clk(clk), .rst_n(rst_n), .io(a_if));

    genius_round_engine #(
        .N_COLORS(8), .MAX_LEN(16), .SHOW_SLOW(T_SLOW), .SHOW_FAST(T_FAST),
        .GAP_CYCLES(T_GAP), .TIMEOUT_CYCLES(T_TO), .LFSR_SEED(16'hACE1)
    ) dut_b (.clk(clk), .rst_n(rst_n), .io(b_if));

    logic [7:0] g_leds, g_score, g_len;
    logic       g_act, g_vic, g_def;
    always_comb begin
        if (sel) begin
            g_leds = b_if.leds;  g_score = b_if.score; g_len = b_if.round_len;
            g_act = b_if.game_active; g_vic = b_if.victory; g_def = b_if.defeat;
        end else begin
            g_leds = {4'b0000, a_if.leds}; g_score = a_if.score; g_len = a_if.round_len;
            g_act = a_if.game_active; g_vic = a_if.victory; g_def = a_if.defeat;
        end
    end

    // Reference LFSR: taps 16,14,13,11 as a parity over a mask.
    logic [15:0] m_lfsr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
    end

    int         total = 0;
    int         bad = 0;
    logic [2:0] seq_m [32];
    int         r;
    bit         mode_m;
    int         s_cyc;
    logic [7:0] led_q [$];

    function automatic logic [7:0] oh(input logic [2:0] c);
        oh = 8'd1 << c;
    endfunction

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // LED scoreboard: each lit step pops the next expected colour; lit duration is checked on release.
    logic [7:0] prev_leds;
    int         on_cnt;
    logic [7:0] exp_led;
    always @(negedge clk) begin
        if (!$onehot0(a_if.leds) || !$onehot0(b_if.leds)) begin
            total++;
            bad++;
            $display("FAIL leds_onehot: got a=%b b=%b want one-hot or zero", a_if.leds, b_if.leds);
        end
        if (!rst_n) begin
            prev_leds <= 8'd0;
            on_cnt    <= 0;
        end else begin
            if (g_leds != 8'd0 && prev_leds == 8'd0) begin
                total++;
                if (led_q.size() == 0) begin
                    bad++;
                    $display("FAIL led_order: got %h want no LED", g_leds);
                end else begin
                    exp_led = led_q.pop_front();
                    if (g_leds != exp_led) begin
                        bad++;
                        $display("FAIL led_order: got %h want %h", g_leds, exp_led);
                    end
                end
                on_cnt <= 1;
            end else if (g_leds != 8'd0) begin
                on_cnt <= on_cnt + 1;
            end else if (prev_leds != 8'd0) begin
                chk("led_on_cycles", on_cnt, s_cyc);
            end
            prev_leds <= g_leds;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset;
        start = 1'b0;
        pi    = 8'd0;
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        led_q.delete();
        step(1);
    endtask

    // Leaves the bench at the negedge inside the EXTEND cycle.
    task automatic start_game(input logic [1:0] d, input bit m);
        diff   = d;
        mode   = m;
        mode_m = m;
        r      = 0;
        start  = 1'b1;
        step(1);
        start  = 1'b0;
    endtask

    // Called in the EXTEND cycle; returns at the first WAIT_INPUT cycle.
    task automatic play_round;
        logic [2:0] c;
        c = sel ? m_lfsr[2:0] : {1'b0, m_lfsr[1:0]};
        seq_m[r] = c;
        r++;
        for (int k = 0; k < r; k++) led_q.push_back(oh(seq_m[k]));
        step(r * (s_cyc + T_GAP) + 1);
        chk("round_len", g_len, r);
        chk("shown_all", led_q.size(), 0);
    endtask

    // 1-cycle press + 2 idle cycles per element; returns in EXTEND/WIN after success or in LOSE.
    task automatic press_all(input bit rev_order, output bit lost);
        int pidx, eidx;
        lost = 1'b0;
        for (int i = 0; i < r; i++) begin
            pidx = rev_order ? r - 1 - i : i;
            eidx = mode_m ? r - 1 - i : i;
            pi = oh(seq_m[pidx]);
            step(1);
            pi = 8'd0;
            if (seq_m[pidx] != seq_m[eidx]) begin
                chk("wrong_press_defeat", g_def, 1);
                lost = 1'b1;
                return;
            end
            chk("alive_after_press", g_def, 0);
            if (i == r - 1) begin
                step(1);
                chk("score", g_score, r);
            end else begin
                step(2);
            end
        end
    endtask

    typedef struct {
        int         kind;      // 0 correct, 1 rotated colour, 2 literal pattern
        logic [3:0] lit;
        int         exp_def;
        int         exp_score;
        int         exp_act;
    } vec_t;

    vec_t       vt [5];
    bit         lost;
    bit         early;
    logic [3:0] e4;

    initial begin
        vt[0] = '{0, 4'b0000, 0, 1, 1};
        vt[1] = '{1, 4'b0000, 1, 0, 0};
        vt[2] = '{2, 4'b0011, 1, 0, 0};
        vt[3] = '{2, 4'b1111, 1, 0, 0};
        vt[4] = '{2, 4'b0101, 1, 0, 0};

        sel = 1'b0; speed = 1'b0; s_cyc = T_SLOW; diff = 2'd0; mode = 1'b0;
        start = 1'b0; pi = 8'd0; rst_n = 1'b0;
        step(1);
        chk("rst_leds", g_leds, 0);
        chk("rst_active", g_act, 0);
        chk("rst_score", g_score, 0);
        chk("rst_len", g_len, 0);
        chk("rst_victory", g_vic, 0);
        chk("rst_defeat", g_def, 0);
        do_reset();

        // Full 8-round classic game.
        start_game(2'd0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            play_round();
            press_all(1'b0, lost);
            if (lost) break;
        end
        chk("win_victory", g_vic, 1);
        chk("win_active", g_act, 0);
        chk("win_len", g_len, 8);
        chk("win_score", g_score, 8);

        // Round-1 response table.
        for (int i = 0; i < 5; i++) begin
            do_reset();
            step(i + 1);
            start_game(2'd0, 1'b0);
            play_round();
            e4 = 4'b0001 << seq_m[0][1:0];
            case (vt[i].kind)
                0:       pi = {4'b0000, e4};
                1:       pi = {4'b0000, e4[2:0], e4[3]};
                default: pi = {4'b0000, vt[i].lit};
            endcase
            step(1);
            pi = 8'd0;
            chk("vec_defeat", g_def, vt[i].exp_def);
            step(1);
            chk("vec_score", g_score, vt[i].exp_score);
            chk("vec_active", g_act, vt[i].exp_act);
        end

        // Button held across WAIT_INPUT entry is not a press until released.
        do_reset();
        start_game(2'd0, 1'b0);
        pi = 8'h0F;
        play_round();
        step(3);
        chk("held_no_defeat", g_def, 0);
        chk("held_active", g_act, 1);
        pi = 8'd0;
        step(1);
        press_all(1'b0, lost);

        // Timeout: defeat exactly T_TO cycles after WAIT_INPUT entry.
        do_reset();
        start_game(2'd0, 1'b0);
        play_round();
        early = 1'b0;
        for (int c = 0; c < T_TO; c++) begin
            if (g_def) early = 1'b1;
            step(1);
        end
        chk("timeout_early", early, 0);
        chk("timeout_defeat", g_def, 1);
        chk("timeout_score", g_score, 0);

        // Reverse mode: correct reverse entry for 3 rounds, then classic order in round 3.
        do_reset();
        start_game(2'd0, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            play_round();
            press_all(1'b1, lost);
        end
        chk("rev_score3", g_score, 3);
        do_reset();
        start_game(2'd0, 1'b1);
        for (int k = 1; k <= 2; k++) begin
            play_round();
            press_all(1'b1, lost);
        end
        play_round();
        press_all(1'b0, lost);

        // Start held through a whole show is ignored; async reset mid-WAIT_INPUT.
        do_reset();
        start_game(2'd0, 1'b0);
        play_round();
        press_all(1'b0, lost);
        start = 1'b1;
        play_round();
        start = 1'b0;
        chk("midstart_score", g_score, 1);
        step(3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_leds", g_leds, 0);
        chk("arst_active", g_act, 0);
        chk("arst_score", g_score, 0);
        chk("arst_len", g_len, 0);
        chk("arst_victory", g_vic, 0);
        chk("arst_defeat", g_def, 0);
        @(negedge clk);
        rst_n = 1'b1;
        led_q.delete();
        step(1);
        start_game(2'd0, 1'b0);
        play_round();
        chk("restart_score", g_score, 0);

        // 8 colours, MAX_LEN=16, difficulty 3 clipped to 16, fast show.
        sel = 1'b1; speed = 1'b1; s_cyc = T_FAST;
        do_reset();
        start_game(2'd3, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            play_round();
            press_all(1'b0, lost);
            if (lost) break;
        end
        chk("b_victory", g_vic, 1);
        chk("b_len", g_len, 16);
        chk("b_score", g_score, 16);
        chk("b_active", g_act, 0);

        step(2);
        chk("led_q_empty", led_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/genius_round_engine.md
Name: genius_round_engine

Overview:
Parametrised Genius/Simon game core, successor to the fixed 4-colour controller. Generates a random colour sequence (internal LFSR), grows it by one step per round, plays it on one-hot LEDs, then checks the player's presses. Adds configurable colour count and maximum length, reverse-entry mode, per-press timeout, and explicit win/lose flags. Sits between the debounced button/switch front-end and the LED/score display drivers.

Parameters:
N_COLORS, 4, number of colours/buttons; power of two in {2,4,8}
MAX_LEN, 32, sequence storage depth; 8..255
SHOW_SLOW, 400, LED-on cycles per step when speed_fast=0
SHOW_FAST, 100, LED-on cycles per step when speed_fast=1
GAP_CYCLES, 50, LED-off cycles between shown steps
TIMEOUT_CYCLES, 2000, maximum idle cycles while waiting for a press
LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  synchronous start pulse
player_input  in  N_COLORS  button levels, one bit per colour
speed_fast  in  1  0: SHOW_SLOW, 1: SHOW_FAST; sampled at each SHOW_ON entry
difficulty  in  2  target length 8/16/24/32, clipped to MAX_LEN; latched on start
game_mode  in  1  0: classic order, 1: reverse order; latched on start
leds  out  N_COLORS  one-hot colour being shown, 0 otherwise
game_active  out  1  high in every state except IDLE, WIN, LOSE
score  out  8  rounds completed, saturating at 255
round_len  out  8  current sequence length
victory  out  1  high in WIN
defeat  out  1  high in LOSE

Behaviour:
- Reset is asynchronous and active-low; clk is the only clock. On reset, all outputs are 0, state is IDLE, and the LFSR is set to LFSR_SEED.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle in every state. The new colour is the low log2(N_COLORS) bits.
- States: IDLE, EXTEND, SHOW_ON, SHOW_OFF, WAIT_INPUT, ROUND_OK, WIN, LOSE.
- IDLE, WIN, LOSE:
  - start=1 latches difficulty and game_mode, clears score and round_len, and moves to EXTEND next cycle.
  - start is ignored in every other state.
- EXTEND (1 cycle): seq[round_len] <= LFSR colour; round_len += 1; show index = 0; next SHOW_ON.
- SHOW_ON: leds = onehot(seq[idx]) for exactly SHOW_x cycles, then SHOW_OFF.
- SHOW_OFF: leds = 0 for GAP_CYCLES cycles, then idx += 1.
  - If idx reaches round_len: go to WAIT_INPUT with idx = 0 (classic) or round_len-1 (reverse), timer cleared.
  - Otherwise return to SHOW_ON.
- Latency: start at cycle t gives EXTEND at t+1 and first LED lit at t+2.
- Press detection in WAIT_INPUT:
  - A press is registered when player_input was all-zero on the previous cycle and is nonzero this cycle.
  - A press with more than one bit set counts as wrong.
  - Holding a button counts once; releasing to zero re-arms detection.
  - Buttons held when WAIT_INPUT is entered are not a press until released.
- WAIT_INPUT: leds = 0 (no echo). The timer increments every cycle and clears on each registered press.
  - Correct press: step idx (+1 classic, -1 reverse).
  - Correct press on the last expected element: next state ROUND_OK.
  - Wrong press: LOSE.
  - Timer reaching TIMEOUT_CYCLES: LOSE.
- ROUND_OK (1 cycle): score += 1, saturating at 255. If round_len == target, go to WIN; else go to EXTEND.
- WIN and LOSE hold victory or defeat high until the next start; leds = 0.
- Reset mid-game returns to IDLE immediately; no partial state survives.
- seq storage is N_COLORS-wide-index by MAX_LEN entries. round_len never exceeds the target, which is always ≤ MAX_LEN.

Test Plan:
1. Params N_COLORS=4, SHOW_SLOW=4, GAP_CYCLES=2, TIMEOUT_CYCLES=20; difficulty=0, mode=0. Pulse start, echo each shown colour as a 1-cycle press followed by 2 idle cycles -> 8 rounds; score steps 1..8; victory=1, game_active=0, round_len=8.
2. Round 1, press the colour rotated by one bit -> defeat=1 on the cycle after the press; score=0.
3. After round 1 is shown, apply no press -> defeat asserts exactly 20 cycles after WAIT_INPUT entry. Also check: 4'b0011 pressed -> defeat.
4. game_mode=1, round 3 with seq A,B,C: press C,B,A -> ROUND_OK, score=3. Pressing A,B,C instead -> defeat on the first press.
5. Start pulse during SHOW_ON -> ignored, round_len unchanged. rst_n=0 mid-WAIT_INPUT -> all outputs 0 asynchronously; the next start begins at round_len=1.
6. N_COLORS=8, MAX_LEN=16, difficulty=3 -> target clipped to 16; victory after 16 rounds; leds is always one-hot or 0 (assertion across the whole run).
